// File: rtl/pc_display_driver.sv
// pc_display_driver: shows the PC as two hex digits on a muxed common-anode 7-seg (i_clk, i_reset active-low async, i_pcIn -> o_seg {g..a}, o_an active-low, o_led stretched PC-to-zero pulse)
module pc_display_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK          = 16,
  parameter int PULSE_LEN      = 25000000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_pcIn,
  output logic [6:0] o_seg,
  output logic [1:0] o_an,
  output logic       o_led
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(PULSE_LEN + 1);
  localparam logic [6:0] OFF = SEG_ACTIVE_LOW != 0 ? 7'h7f : 7'h00;
  localparam logic [111:0] HEX = {7'h71, 7'h79, 7'h5e, 7'h39, 7'h7c, 7'h77, 7'h6f, 7'h7f,
                                  7'h07, 7'h7d, 7'h6d, 7'h66, 7'h4f, 7'h5b, 7'h06, 7'h3f};
  logic [CW-1:0] cnt;
  logic          idx;
  logic [7:0]    disp;
  logic [7:0]    prev;
  logic [SW-1:0] st;
  logic          wrap;
  logic          blank;
  logic          ev;
  logic [3:0]    nib;
  logic [6:0]    base;
  logic [6:0]    glyph;
  always_comb begin
    wrap  = cnt == CW'(SCAN_DIV - 1);
    blank = cnt < CW'(BLANK);
    ev    = i_pcIn == 8'h00 && prev != 8'h00;
    nib   = idx ? disp[7:4] : disp[3:0];
    base  = 7'(nib) * 7'd7;
    glyph = SEG_ACTIVE_LOW != 0 ? ~HEX[base +: 7] : HEX[base +: 7];
    o_led = st != '0;
  end
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      cnt   <= '0;
      idx   <= 1'b0;
      disp  <= 8'h00;
      prev  <= 8'h00;
      st    <= '0;
      o_an  <= 2'b11;
      o_seg <= OFF;
    end else begin
      cnt   <= wrap ? '0 : cnt + CW'(1);
      idx   <= wrap ? ~idx : idx;
      disp  <= wrap && idx ? i_pcIn : disp;
      prev  <= i_pcIn;
      st    <= ev ? SW'(PULSE_LEN) : st - SW'(st != '0);
      o_an  <= blank ? 2'b11 : idx ? 2'b01 : 2'b10;
      o_seg <= blank ? OFF : glyph;
    end
  end
endmodule

// File: doc/pc_display_driver.md
Name: pc_display_driver

Overview:
- Output-side companion to the reset debouncer. The debouncer takes a human button press into the PC path; this block takes the PC value back out to the human.
- Shows the 8-bit program counter as two hex digits on a time-multiplexed common-anode 7-segment display.
- Lights a stretched LED whenever the PC is forced back to zero, so a debounced reset is visible on the board.
- Sits at the top level between the PC register and the board display pins.

Parameters:
- SCAN_DIV, 50000: clock cycles per digit slot. Legal range 4..2^24.
- BLANK, 16: cycles at the start of each slot with all anodes off (anti-ghosting). Must be < SCAN_DIV.
- PULSE_LEN, 25000000: o_led on-time in cycles after a PC-to-zero event. Must be ≥ 1.
- SEG_ACTIVE_LOW, 1: 1 = segment lit when its bit is 0; 0 = lit when its bit is 1.

Ports:
- i_clk, in, 1: system clock.
- i_reset, in, 1: asynchronous, active-low reset (0 = reset asserted).
- i_pcIn, in, 8: current PC value, synchronous to i_clk.
- o_seg, out, 7: segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- o_an, out, 2: digit anodes, active-low. Bit 0 = low-nibble digit, bit 1 = high-nibble digit.
- o_led, out, 1: PC-reset indicator, active-high.

Behaviour:
- Reset (i_reset=0, asynchronous), all registers cleared:
  - scan counter = 0; digit index = 0; display register = 8'h00; previous-PC register = 8'h00; stretch counter = 0.
  - o_an = 2'b11; o_seg = all segments off (7'h7F if SEG_ACTIVE_LOW else 7'h00); o_led = 0.
- Scan counter:
  - Counts 0..SCAN_DIV-1, then wraps to 0.
  - On the wrap, the digit index toggles.
  - When the index toggles 1→0 (frame boundary), the display register loads i_pcIn in that same cycle.
  - The displayed value therefore changes only at frame boundaries; both digits always come from the same snapshot.
- Anode drive, registered (one cycle behind the counter):
  - Counter < BLANK: o_an = 2'b11.
  - Otherwise: index 0 gives o_an = 2'b10; index 1 gives o_an = 2'b01.
  - Two anodes are never active in the same cycle.
- Segment drive:
  - Nibble selected by the index, registered in the same cycle as o_an.
  - Standard hex glyphs 0–F. Active-high encoding (gfedcba): 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
  - Inverted when SEG_ACTIVE_LOW=1.
  - o_seg forced to all-off while o_an = 2'b11.
- PC-zero detect:
  - The previous-PC register samples i_pcIn every cycle.
  - Event condition: i_pcIn == 0 and previous != 0.
  - On an event, the stretch counter loads PULSE_LEN.
  - Otherwise the counter decrements if nonzero, saturating at 0.
  - o_led = (stretch counter != 0), registered: rises the cycle after the event.
  - An event while the counter is running reloads PULSE_LEN (retrigger), with no gap in o_led.
- Boundary conditions:
  - PC held at 0 from reset onward produces no event, so o_led stays 0.
  - PC changes mid-frame: not shown until the next frame boundary.
  - Reset mid-scan or mid-stretch: all outputs return to their reset values immediately, independent of i_clk.
  - Scanning restarts at index 0 with a blank slot on the first clock after reset is released.

Test Plan (SCAN_DIV=8, BLANK=2, PULSE_LEN=20, SEG_ACTIVE_LOW=1):
1. Hold i_reset=0, toggle i_clk -> o_an=11, o_seg=7F, o_led=0 throughout. Assert reset asynchronously between clock edges -> outputs change before the next edge.
2. Release reset with i_pcIn=8'h3A -> first frame shows 00. After the first 1→0 index wrap: index-0 slot has o_an=10 for 6 cycles with o_seg=~77=08, preceded by 2 cycles of 11; index-1 slot has o_an=01 with o_seg=~4F=30.
3. Change i_pcIn 3A→C5 mid index-1 slot -> current frame still shows 3A. Next frame shows low digit 5 (o_seg=12) and high digit C (o_seg=46).
4. i_pcIn 8'h07→8'h00 at cycle T -> o_led=1 from T+1 for exactly 20 cycles, then 0. Display shows 00 from the next frame boundary.
5. Second 0-event (PC 00→04→00) at T+10 -> o_led stays high continuously until T+31.
6. Check every cycle of all runs -> o_an is never 2'b00.
